// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - GF(2^8) helpers, MixColumns mode codes and engine FSM state type
package aes_pkg;

  localparam logic [1:0] MC_FWD = 2'd0;
  localparam logic [1:0] MC_INV = 2'd1;
  localparam logic [1:0] MC_BYP = 2'd2;
  localparam logic [1:0] MC_RSV = 2'd3;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mixcolumn_word.sv
// rtl/mixcolumn_word.sv - combinational forward/inverse MixColumns on one 32-bit column
module mixcolumn_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] fwd_col, inv_col;

  assign {a0, a1, a2, a3} = col_i;

  always_comb begin
    fwd_col[31:24] = gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3;
    fwd_col[23:16] = a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3;
    fwd_col[15:8]  = a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3;
    fwd_col[7:0]   = gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3);

    inv_col[31:24] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
    inv_col[23:16] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
    inv_col[15:8]  = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
    inv_col[7:0]   = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
  end

  assign col_o = inv_i ? inv_col : fwd_col;

endmodule

// File: rtl/mixcolumns_engine.sv
// rtl/mixcolumns_engine.sv - handshaked iterative AES MixColumns (fwd/inv/bypass)
module mixcolumns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4,
  parameter int OUT_REG        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  mc_state_e    state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic         inv_q, inv_d;

  logic [127:0] work_xf;
  logic         last_grp, accept, rdy_w, vld_w;
  logic         mode_inv, mode_byp;

  logic [1:0]   col_idx [COLS_PER_CYCLE];
  logic [31:0]  col_in  [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];

  function automatic logic [31:0] col_get(input logic [127:0] s, input logic [1:0] i);
    logic [31:0] c;
    case (i)
      2'd0:    c = s[127:96];
      2'd1:    c = s[95:64];
      2'd2:    c = s[63:32];
      default: c = s[31:0];
    endcase
    return c;
  endfunction

  assign last_grp = (cnt_q == CNT_LAST);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_in[g]  = col_get(work_q, col_idx[g]);
    mixcolumn_word u_word (
      .col_i (col_in[g]),
      .inv_i (inv_q),
      .col_o (col_out[g])
    );
  end

  // Write the transformed column group back over its slots in the working state.
  always_comb begin
    work_xf = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      case (col_idx[g])
        2'd0:    work_xf[127:96] = col_out[g];
        2'd1:    work_xf[95:64]  = col_out[g];
        2'd2:    work_xf[63:32]  = col_out[g];
        default: work_xf[31:0]   = col_out[g];
      endcase
    end
  end

  always_comb begin
    mode_inv = 1'b0;
    mode_byp = 1'b0;
    case (in_mode)
      MC_FWD:         mode_inv = 1'b0;
      MC_INV:         mode_inv = 1'b1;
      MC_BYP, MC_RSV: mode_byp = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    rdy_w   = 1'b0;
    vld_w   = 1'b0;
    case (state_q)
      MC_IDLE: rdy_w = 1'b1;
      MC_BUSY: begin
        work_d = work_xf;
        cnt_d  = cnt_q + CNT_STEP;
        if (last_grp) begin
          // Without an output register the result is already visible in this cycle.
          vld_w   = (OUT_REG == 0);
          state_d = (OUT_REG == 0 && out_ready) ? MC_IDLE : MC_DONE;
        end
      end
      MC_DONE: begin
        vld_w = 1'b1;
        rdy_w = out_ready;
        if (out_ready) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
    if (rst) rdy_w = 1'b0;
    accept = in_valid && rdy_w;
    if (accept) begin
      work_d  = in_state;
      inv_d   = mode_inv;
      cnt_d   = 2'd0;
      state_d = mode_byp ? MC_DONE : MC_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [127:0] out_q, out_d;

    always_comb begin
      out_d = out_q;
      if (state_q == MC_BUSY && last_grp) out_d = work_xf;
      if (accept && mode_byp) out_d = in_state;
    end

    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
    end

    assign out_state = out_q;
  end else begin : g_out_comb
    assign out_state = (state_q == MC_BUSY) ? work_xf : work_q;
  end

  assign in_ready  = rdy_w;
  assign out_valid = vld_w;
  assign busy      = (state_q == MC_BUSY) || (state_q == MC_DONE);

endmodule
